// File: rtl/ddt_panel_sequencer.sv
// ddt_panel_sequencer
//   Power-up, blanking and test-pattern controller placed between the DDT
//   timing generator and the RGB output pins. It steps the panel supply and
//   backlight through OFF -> PWR_UP -> BLANK -> RUN -> PWR_DOWN. Every
//   transition except OFF -> PWR_UP and the Enable-drop exit is counted in
//   frame starts. In RUN it drives a registered RGB test pattern.
//
// Configuration macro: DDT_SEQ_PATTERN_CYCLE_EN
//   defined   : in RUN the pattern index advances every FRAMES_PER_PATTERN
//               frames and wraps after NUM_PATTERNS. Pattern_Sel is ignored.
//   undefined : the pattern index loads Pattern_Sel on every frame start.
//
// Ports
//   DDT_Clock           pixel clock, all logic on posedge
//   Reset               synchronous, active-low
//   Enable              level request: 1 = panel on, 0 = panel off
//   DDT_VSA             vertical sync; its rising edge marks a frame start
//   DDT_DE              data enable from the timing generator
//   DDT_Pixel_Data_Cnt  active-pixel index within the line
//   DDT_Line_Data_Cnt   active-line index (not needed by any pattern)
//   Pattern_Sel         static pattern select
//   Panel_Power         panel supply enable
//   Backlight_En        backlight enable
//   Seq_State           OFF=0 PWR_UP=1 BLANK=2 RUN=3 PWR_DOWN=4
//   Pattern_Idx         active pattern
//   Frame_Cnt           frames since entering RUN (wraps, 0 outside RUN)
//   Out_DE              registered DDT_DE, held at 0 in OFF
//   Out_R/Out_G/Out_B   registered pixel data, black outside RUN or DE
module ddt_panel_sequencer #(
  parameter int unsigned PWR_UP_FRAMES      = 2,
  parameter int unsigned BLANK_FRAMES       = 1,
  parameter int unsigned FRAMES_PER_PATTERN = 60,
  parameter int unsigned NUM_PATTERNS       = 4
) (
  input  logic        DDT_Clock,
  input  logic        Reset,
  input  logic        Enable,
  input  logic        DDT_VSA,
  input  logic        DDT_DE,
  input  logic [15:0] DDT_Pixel_Data_Cnt,
  input  logic [15:0] DDT_Line_Data_Cnt,
  input  logic [1:0]  Pattern_Sel,
  output logic        Panel_Power,
  output logic        Backlight_En,
  output logic [2:0]  Seq_State,
  output logic [1:0]  Pattern_Idx,
  output logic [15:0] Frame_Cnt,
  output logic        Out_DE,
  output logic [7:0]  Out_R,
  output logic [7:0]  Out_G,
  output logic [7:0]  Out_B
);

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_PWR_UP   = 3'd1,
    ST_BLANK    = 3'd2,
    ST_RUN      = 3'd3,
    ST_PWR_DOWN = 3'd4
  } state_e;

  // Pattern generator; p is the low byte of the active-pixel index.
  function automatic logic [23:0] pattern_rgb(input logic [1:0] idx, input logic [7:0] p);
    logic [23:0] rgb;
    case (idx)
      2'd0:    rgb = p[0] ? 24'hFF_FF_FF : 24'h00_00_00;
      2'd1:    rgb = 24'hFF_FF_FF;
      2'd2:    rgb = {{8{p[7]}}, {8{p[6]}}, {8{p[5]}}};
      2'd3:    rgb = {p, p, p};
      default: rgb = 24'h00_00_00;
    endcase
    return rgb;
  endfunction

  state_e      state_q, state_d;
  logic        vsa_q;
  logic        fs_s;
  logic [15:0] stage_cnt_q, stage_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic        power_q, backlight_q, out_de_q;
  logic [23:0] rgb_q, rgb_d;
  logic        unused_s;

  // The line counter and upper pixel bits feed no pattern.
  assign unused_s = ^{DDT_Line_Data_Cnt, DDT_Pixel_Data_Cnt[15:8], Pattern_Sel};

  assign fs_s = DDT_VSA & ~vsa_q;

  // Next-state logic. Enable=0 is tested before the frame-start check so
  // that it wins over a transition driven by a simultaneous FS.
  always_comb begin
    state_d     = state_q;
    stage_cnt_d = stage_cnt_q;
    case (state_q)
      ST_OFF: begin
        if (Enable) state_d = ST_PWR_UP;
        else        state_d = ST_OFF;
      end
      ST_PWR_UP: begin
        if (!Enable) begin
          state_d = ST_PWR_DOWN;
        end else if (fs_s) begin
          if (stage_cnt_q + 16'd1 == 16'(PWR_UP_FRAMES)) state_d = ST_BLANK;
          else stage_cnt_d = stage_cnt_q + 16'd1;
        end else begin
          state_d = ST_PWR_UP;
        end
      end
      ST_BLANK: begin
        if (!Enable) begin
          state_d = ST_PWR_DOWN;
        end else if (fs_s) begin
          if (stage_cnt_q + 16'd1 == 16'(BLANK_FRAMES)) state_d = ST_RUN;
          else stage_cnt_d = stage_cnt_q + 16'd1;
        end else begin
          state_d = ST_BLANK;
        end
      end
      ST_RUN: begin
        if (!Enable) state_d = ST_PWR_DOWN;
        else         state_d = ST_RUN;
      end
      ST_PWR_DOWN: begin
        // Enable is deliberately not looked at until OFF is reached.
        if (fs_s) state_d = ST_OFF;
        else      state_d = ST_PWR_DOWN;
      end
      default: state_d = ST_OFF;
    endcase
    if (state_d != state_q) stage_cnt_d = 16'd0;
    else                    stage_cnt_d = stage_cnt_d;
  end

  // Frame_Cnt counts only FS pulses seen while already in RUN, so the FS
  // that causes RUN entry is not counted.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_d != ST_RUN)   frame_cnt_d = 16'd0;
    else if (state_q != ST_RUN) frame_cnt_d = 16'd0;
    else if (fs_s)           frame_cnt_d = frame_cnt_q + 16'd1;
    else                     frame_cnt_d = frame_cnt_q;
  end

`ifdef DDT_SEQ_PATTERN_CYCLE_EN
  logic [15:0] pat_cnt_q, pat_cnt_d;

  // Auto-cycle: advance on the FS that completes FRAMES_PER_PATTERN frames.
  always_comb begin
    idx_d     = idx_q;
    pat_cnt_d = pat_cnt_q;
    if (state_d == ST_RUN && state_q != ST_RUN) begin
      idx_d     = 2'd0;
      pat_cnt_d = 16'd0;
    end else if (state_d == ST_RUN && fs_s) begin
      if (pat_cnt_q + 16'd1 == 16'(FRAMES_PER_PATTERN)) begin
        pat_cnt_d = 16'd0;
        if (idx_q == 2'(NUM_PATTERNS - 1)) idx_d = 2'd0;
        else                               idx_d = idx_q + 2'd1;
      end else begin
        pat_cnt_d = pat_cnt_q + 16'd1;
      end
    end else begin
      idx_d     = idx_q;
      pat_cnt_d = pat_cnt_q;
    end
  end

  // Per-pattern frame counter register.
  always_ff @(posedge DDT_Clock) begin
    if (!Reset) pat_cnt_q <= 16'd0;
    else        pat_cnt_q <= pat_cnt_d;
  end
`else
  // Static select, sampled only on frame starts so it never changes mid-frame.
  always_comb begin
    idx_d = idx_q;
    if (fs_s) idx_d = Pattern_Sel;
    else      idx_d = idx_q;
  end
`endif

  // Pixel path: black outside RUN or outside active video.
  always_comb begin
    rgb_d = 24'h00_00_00;
    if (DDT_DE && state_d == ST_RUN) rgb_d = pattern_rgb(idx_d, DDT_Pixel_Data_Cnt[7:0]);
    else                             rgb_d = 24'h00_00_00;
  end

  // State, counters and registered outputs. Outputs are derived from the
  // next state so they change in the same cycle as Seq_State.
  always_ff @(posedge DDT_Clock) begin
    if (!Reset) begin
      state_q     <= ST_OFF;
      vsa_q       <= 1'b0;
      stage_cnt_q <= 16'd0;
      frame_cnt_q <= 16'd0;
      idx_q       <= 2'd0;
      power_q     <= 1'b0;
      backlight_q <= 1'b0;
      out_de_q    <= 1'b0;
      rgb_q       <= 24'h00_00_00;
    end else begin
      state_q     <= state_d;
      vsa_q       <= DDT_VSA;
      stage_cnt_q <= stage_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      idx_q       <= idx_d;
      power_q     <= (state_d != ST_OFF);
      backlight_q <= (state_d == ST_RUN);
      out_de_q    <= DDT_DE & (state_d != ST_OFF);
      rgb_q       <= rgb_d;
    end
  end

  assign Seq_State    = state_q;
  assign Panel_Power  = power_q;
  assign Backlight_En = backlight_q;
  assign Pattern_Idx  = idx_q;
  assign Frame_Cnt    = frame_cnt_q;
  assign Out_DE       = out_de_q;
  assign Out_R        = rgb_q[23:16];
  assign Out_G        = rgb_q[15:8];
  assign Out_B        = rgb_q[7:0];

endmodule
